fa16_rev_seq: RTL and testbench
===============================

# fa16_rev_seq

Clocked sequencer for the combinational reversible 16-bit adder `fa16_rev_ctrl`. It accepts forward, backward or round-trip operations on a valid/ready request port and drives `dir` and the forward/backward operand ports. It waits a programmable settle time, captures the results and returns them on a valid/ready response port. In round-trip mode it checks that the recovered inputs equal the originals and counts mismatches; it sits between the PE control logic and the adder datapath.

## Interface
- `SETTLE`, 2, cycles the adder is allowed to settle per direction; legal values ≥1
- `ERRW`, 8, width of the mismatch counter
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `VDD`, `VSS`  inout  1  power pins, present only under `USE_POWER_PINS`
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request ready
- `req_mode`  in  2  operation mode: 00 FWD, 01 BWD, 10 RT, 11 illegal
- `req_x`, `req_y`  in  16  a/b for FWD and RT; s/a_b for BWD
- `req_c`, `req_z`  in  1  c0_f/z for FWD and RT; c0_b/c15 for BWD
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response ready
- `rsp_x`, `rsp_y`  out  16  result words
- `rsp_c`, `rsp_z`  out  1  result bits
- `rsp_mismatch`  out  1  set on an RT failure or an illegal mode
- `err_count`  out  ERRW  saturating count of `rsp_mismatch` responses
- `dir`  out  1  adder direction: 0 forward, 1 backward
- `f_a`, `f_b`  out  16;  `f_c0_f`, `f_z`  out  1  forward operands, registered
- `f_s`, `f_a_b`  in  16;  `f_c0_b`, `f_c15`  in  1  forward results
- `r_s`, `r_a_b`  out  16;  `r_c0_b`, `r_c15`  out  1  backward operands, registered
- `r_a`, `r_b`  in  16;  `r_c0_f`, `r_z`  in  1  backward results

## Operation
- **FSM states:** IDLE, FWD_WAIT, BWD_SETUP, BWD_WAIT, RESP.
- **IDLE:** `req_ready`=1. On `req_valid`&`req_ready` the request is latched.
  - FWD: load `f_*` from `req_*`, go to FWD_WAIT.
  - BWD: load `r_*` from `req_*`, go to BWD_SETUP.
  - RT: load `f_*` from `req_*`, go to FWD_WAIT.
  - Illegal (11): go to RESP with data 0 and `rsp_mismatch`=1.
- **FWD_WAIT:** `dir`=0. A down-counter is loaded with SETTLE-1 on entry; the state is left when the counter reaches 0.
  - FWD: `f_s`, `f_a_b`, `f_c0_b`, `f_c15` are captured into `rsp_*`, then RESP.
  - RT: the same values are captured into `r_*`, then BWD_SETUP.
- **BWD_SETUP:** one cycle with `dir`=0 and `r_*` already stable. This is a break-before-make guard so `dir` never flips while the backward operands change.
- **BWD_WAIT:** `dir`=1 for SETTLE cycles. On the final cycle `r_a`, `r_b`, `r_c0_f`, `r_z` are captured into `rsp_*`.
  - RT only: `rsp_mismatch` = recovered values ≠ original request values.
  - Next state is RESP.
- **RESP:** `dir`=0 and `rsp_valid`=1. Data is held stable until `rsp_ready`; on that handshake the FSM returns to IDLE.
  - The request is not bypassed: `req_ready` rises in the cycle after the handshake.
- **err_count:** increments by 1 on each response handshake with `rsp_mismatch`=1. It saturates at 2^ERRW-1.
- `f_*` and `r_*` hold their values between operations; they are reloaded only by the next accepted request or an RT capture.

## Timing
- Cycle numbering: the accept edge ends cycle 0.
  - FWD: `rsp_valid` from cycle SETTLE+1.
  - BWD: `rsp_valid` from cycle SETTLE+2.
  - RT: `rsp_valid` from cycle 2·SETTLE+2.
  - Illegal: `rsp_valid` from cycle 1.
  - With SETTLE=2 these are 3, 4, 6 and 1.
- In RT, `dir` rises at the start of cycle SETTLE+2 and falls at the start of the RESP cycle.
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `dir`=0. All other outputs, including `err_count`, are 0.
- **Reset mid-operation:** all registers clear asynchronously and `dir` drops to 0 at once. The in-flight operation is discarded with no response.
- **Backpressure:** `rsp_*` must be stable while `rsp_valid`=1 and `rsp_ready`=0. `req_ready` stays 0 from the accept edge until the cycle after the response handshake.
- `req_*` are sampled only at the accept edge; changes at any other time have no effect.

## Structure
- **Package `fa16_rev_pkg`:** width constant `FA_W`=16, the `mode_e` enum (FWD, BWD, RT, ILL) and the `state_e` enum.
- **Sub-module `fa16_rev_settle_cnt`:** load/decrement settle counter with a `done` output.
- The integration top `fa16_rev_sys` instantiates `fa16_rev_seq` and `fa16_rev_ctrl`. That top is outside this block.

## Test plan
All scenarios use SETTLE=2 and the real `fa16_rev_ctrl` instance.
- **Round trip:** RT with a=0x1234, b=0xABCD, c=1, z=0 → `rsp_valid` at cycle 6 with x=0x1234, y=0xABCD, c=1, z=0, mismatch=0. `dir` is high only in cycles 4-5.
- **Forward then backward:** FWD with a=0xFFFF, b=0x0001, c=0, z=0 at cycle 3, then BWD fed that response → returns 0xFFFF, 0x0001, 0, 0 at cycle 4.
- **Fault injection:** force `r_a`[0] inverted during RT → mismatch=1. `err_count` goes 0→1 on the handshake; 255 forced faults leave it at 255.
- **Backpressure:** `rsp_ready`=0 for 5 cycles → `rsp_*` stable, `req_ready`=0, and a pending `req_valid` is not accepted until the cycle after the handshake.
- **Illegal mode:** `req_mode`=11 → `rsp_valid` at cycle 1, data 0, mismatch=1, `dir` stays 0.
- **Reset mid-RT:** assert `rst_n`=0 at cycle 4 of an RT → `dir`=0 immediately, `rsp_valid` never rises, `err_count`=0, `req_ready`=1 after release.

Source files
------------

// File: rtl/fa16_rev_pkg.sv
// fa16_rev_pkg
// Shared definitions for the reversible 16-bit adder sequencer:
//   FA_W    - datapath width of the adder operands/results
//   mode_e  - request operation code carried on req_mode
//   state_e - sequencer FSM state encoding
package fa16_rev_pkg;

    localparam int unsigned FA_W = 16;

    typedef enum logic [1:0] {
        MODE_FWD = 2'b00,
        MODE_BWD = 2'b01,
        MODE_RT  = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD_WAIT,
        ST_BWD_SETUP,
        ST_BWD_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/fa16_rev_settle_cnt.sv
// fa16_rev_settle_cnt
// Load/decrement down-counter that times the adder settle window.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load load_val (takes priority over dec)
//   load_val   - value loaded on load
//   dec        - decrement by one while non-zero
//   done       - counter is zero
module fa16_rev_settle_cnt #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          done
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/fa16_rev_seq.sv
// fa16_rev_seq
// Clocked sequencer for the combinational reversible adder fa16_rev_ctrl.
// Accepts FWD / BWD / round-trip (RT) requests, drives the adder operands
// and direction, waits SETTLE cycles per direction and returns the captured
// results. RT compares the recovered inputs against the originals.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   VDD, VSS                - power pins (USE_POWER_PINS only)
//   req_valid/ready/mode    - request handshake and operation code
//   req_x, req_y, req_c, req_z - request operands
//   rsp_valid/ready         - response handshake
//   rsp_x, rsp_y, rsp_c, rsp_z - result data
//   rsp_mismatch            - RT recovery failure or illegal mode
//   err_count               - saturating count of mismatch responses
//   dir                     - adder direction, 0 forward / 1 backward
//   f_* out / f_* in        - forward operands / forward results
//   r_* out / r_* in        - backward operands / backward results
module fa16_rev_seq
    import fa16_rev_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERRW   = 8
) (
`ifdef USE_POWER_PINS
    inout  logic            VDD,
    inout  logic            VSS,
`endif
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_mode,
    input  logic [FA_W-1:0] req_x,
    input  logic [FA_W-1:0] req_y,
    input  logic            req_c,
    input  logic            req_z,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [FA_W-1:0] rsp_x,
    output logic [FA_W-1:0] rsp_y,
    output logic            rsp_c,
    output logic            rsp_z,
    output logic            rsp_mismatch,
    output logic [ERRW-1:0] err_count,
    output logic            dir,
    output logic [FA_W-1:0] f_a,
    output logic [FA_W-1:0] f_b,
    output logic            f_c0_f,
    output logic            f_z,
    input  logic [FA_W-1:0] f_s,
    input  logic [FA_W-1:0] f_a_b,
    input  logic            f_c0_b,
    input  logic            f_c15,
    output logic [FA_W-1:0] r_s,
    output logic [FA_W-1:0] r_a_b,
    output logic            r_c0_b,
    output logic            r_c15,
    input  logic [FA_W-1:0] r_a,
    input  logic [FA_W-1:0] r_b,
    input  logic            r_c0_f,
    input  logic            r_z
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e state_q, state_d;
    mode_e  mode_q;
    mode_e  req_mode_e;
    logic   accept;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_done;
    logic   rt_bad;

    assign req_mode_e = mode_e'(req_mode);
    assign accept     = (state_q == ST_IDLE) && req_valid;

    // The originals stay in f_* for the whole RT, so they double as the
    // reference for the recovery check.
    assign rt_bad = (r_a != f_a) || (r_b != f_b) ||
                    (r_c0_f != f_c0_f) || (r_z != f_z);

    // Counter reloads on every entry into a wait state.
    assign cnt_load = ((state_d == ST_FWD_WAIT) || (state_d == ST_BWD_WAIT)) &&
                      (state_d != state_q);
    assign cnt_dec  = (state_q == ST_FWD_WAIT) || (state_q == ST_BWD_WAIT);

    fa16_rev_settle_cnt #(
        .CW (CW)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CW'(SETTLE - 1)),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    unique case (req_mode_e)
                        MODE_FWD, MODE_RT: state_d = ST_FWD_WAIT;
                        MODE_BWD:          state_d = ST_BWD_SETUP;
                        default:           state_d = ST_RESP;
                    endcase
                end
            end
            ST_FWD_WAIT: begin
                if (cnt_done) begin
                    state_d = (mode_q == MODE_RT) ? ST_BWD_SETUP : ST_RESP;
                end
            end
            ST_BWD_SETUP: state_d = ST_BWD_WAIT;
            ST_BWD_WAIT: begin
                if (cnt_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so reset drops dir at once.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        dir       = (state_q == ST_BWD_WAIT);
    end

    // Operand, capture and error-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_FWD;
            f_a          <= '0;
            f_b          <= '0;
            f_c0_f       <= 1'b0;
            f_z          <= 1'b0;
            r_s          <= '0;
            r_a_b        <= '0;
            r_c0_b       <= 1'b0;
            r_c15        <= 1'b0;
            rsp_x        <= '0;
            rsp_y        <= '0;
            rsp_c        <= 1'b0;
            rsp_z        <= 1'b0;
            rsp_mismatch <= 1'b0;
            err_count    <= '0;
        end else begin
            if (accept) begin
                mode_q <= req_mode_e;
                unique case (req_mode_e)
                    MODE_FWD, MODE_RT: begin
                        f_a    <= req_x;
                        f_b    <= req_y;
                        f_c0_f <= req_c;
                        f_z    <= req_z;
                    end
                    MODE_BWD: begin
                        r_s    <= req_x;
                        r_a_b  <= req_y;
                        r_c0_b <= req_c;
                        r_c15  <= req_z;
                    end
                    default: begin
                        rsp_x        <= '0;
                        rsp_y        <= '0;
                        rsp_c        <= 1'b0;
                        rsp_z        <= 1'b0;
                        rsp_mismatch <= 1'b1;
                    end
                endcase
            end

            if ((state_q == ST_FWD_WAIT) && cnt_done) begin
                if (mode_q == MODE_RT) begin
                    r_s    <= f_s;
                    r_a_b  <= f_a_b;
                    r_c0_b <= f_c0_b;
                    r_c15  <= f_c15;
                end else begin
                    rsp_x        <= f_s;
                    rsp_y        <= f_a_b;
                    rsp_c        <= f_c0_b;
                    rsp_z        <= f_c15;
                    rsp_mismatch <= 1'b0;
                end
            end

            if ((state_q == ST_BWD_WAIT) && cnt_done) begin
                rsp_x        <= r_a;
                rsp_y        <= r_b;
                rsp_c        <= r_c0_f;
                rsp_z        <= r_z;
                rsp_mismatch <= (mode_q == MODE_RT) && rt_bad;
            end

            if ((state_q == ST_RESP) && rsp_ready && rsp_mismatch &&
                (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fa16_rev_seq.sv
// tb_fa16_rev_seq
// Directed bench for fa16_rev_seq with SETTLE=2. A behavioural reversible
// adder stands in for fa16_rev_ctrl:
//   forward : s = a+b+c0 (low 16), a_b = a, c0_b = c0, c15 = z ^ carry
//   backward: a = a_b, b = s-a_b-c0, c0_f = c0_b, z = c15 ^ carry(a+b+c0)
// A fault flag inverts the recovered a[0] to exercise the mismatch path.
module tb_fa16_rev_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_mode;
    logic [15:0] req_x, req_y;
    logic        req_c, req_z;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_x, rsp_y;
    logic        rsp_c, rsp_z, rsp_mismatch;
    logic [7:0]  err_count;
    logic        dir;
    logic [15:0] f_a, f_b, f_s, f_a_b;
    logic        f_c0_f, f_z, f_c0_b, f_c15;
    logic [15:0] r_s, r_a_b, r_a, r_b;
    logic        r_c0_b, r_c15, r_c0_f, r_z;
    logic        fault;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    fa16_rev_seq #(
        .SETTLE (2),
        .ERRW   (8)
    ) dut (
`ifdef USE_POWER_PINS
        .VDD          (),
        .VSS          (),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_c        (req_c),
        .req_z        (req_z),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_x        (rsp_x),
        .rsp_y        (rsp_y),
        .rsp_c        (rsp_c),
        .rsp_z        (rsp_z),
        .rsp_mismatch (rsp_mismatch),
        .err_count    (err_count),
        .dir          (dir),
        .f_a          (f_a),
        .f_b          (f_b),
        .f_c0_f       (f_c0_f),
        .f_z          (f_z),
        .f_s          (f_s),
        .f_a_b        (f_a_b),
        .f_c0_b       (f_c0_b),
        .f_c15        (f_c15),
        .r_s          (r_s),
        .r_a_b        (r_a_b),
        .r_c0_b       (r_c0_b),
        .r_c15        (r_c15),
        .r_a          (r_a),
        .r_b          (r_b),
        .r_c0_f       (r_c0_f),
        .r_z          (r_z)
    );

    // Behavioural adder model
    logic [16:0] f_sum;
    logic [15:0] b_raw;
    logic [16:0] b_sum;
    assign f_sum  = {1'b0, f_a} + {1'b0, f_b} + {16'b0, f_c0_f};
    assign f_s    = f_sum[15:0];
    assign f_a_b  = f_a;
    assign f_c0_b = f_c0_f;
    assign f_c15  = f_z ^ f_sum[16];
    assign b_raw  = r_s - r_a_b - {15'b0, r_c0_b};
    assign b_sum  = {1'b0, r_a_b} + {1'b0, b_raw} + {16'b0, r_c0_b};
    assign r_a    = r_a_b ^ {15'b0, fault};
    assign r_b    = b_raw;
    assign r_c0_f = r_c0_b;
    assign r_z    = r_c15 ^ b_sum[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a request for one accept edge, then scrambles req_* so any
    // late sampling shows up as wrong results.
    task automatic send(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic z);
        @(negedge clk);
        check("send.req_ready", req_ready, 1);
        req_mode  = m;
        req_x     = x;
        req_y     = y;
        req_c     = c;
        req_z     = z;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_mode  = 2'b11;
        req_x     = 16'hDEAD;
        req_y     = 16'hBEEF;
        req_c     = ~c;
        req_z     = ~z;
    endtask

    // Returns the cycle (accept edge ends cycle 0) where rsp_valid is first
    // seen, 0 on timeout, plus a per-cycle record of dir.
    task automatic wait_rsp(output int lat, output logic [15:0] dmask);
        lat   = 0;
        dmask = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n < 16) dmask[n] = dir;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [1:0] m,
                      input logic [15:0] x, input logic [15:0] y, input logic c, input logic z,
                      input int e_lat, input logic [15:0] e_x, input logic [15:0] e_y,
                      input logic e_c, input logic e_z, input logic e_mis,
                      input logic [15:0] e_dmask);
        int          lat;
        logic [15:0] dmask;
        send(m, x, y, c, z);
        wait_rsp(lat, dmask);
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".x"}, rsp_x, e_x);
        check({tag, ".y"}, rsp_y, e_y);
        check({tag, ".c"}, rsp_c, e_c);
        check({tag, ".z"}, rsp_z, e_z);
        check({tag, ".mis"}, rsp_mismatch, e_mis);
        check({tag, ".dir"}, dmask, e_dmask);
        handshake();
        if (e_mis && exp_err < 255) exp_err++;
        @(negedge clk);
        check({tag, ".err"}, err_count, exp_err);
        check({tag, ".ready"}, req_ready, 1);
        check({tag, ".valid_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int          lat;
        logic [15:0] dmask;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 2'b00;
        req_x     = '0;
        req_y     = '0;
        req_c     = 1'b0;
        req_z     = 1'b0;
        rsp_ready = 1'b0;
        fault     = 1'b0;

        #12;
        check("rst.req_ready", req_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.dir", dir, 0);
        check("rst.err", err_count, 0);
        check("rst.f_a", f_a, 0);
        check("rst.r_s", r_s, 0);
        check("rst.rsp_x", rsp_x, 0);
        check("rst.mis", rsp_mismatch, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round trips: dir high only in cycles 4-5
        op("rt1", 2'b10, 16'h1234, 16'hABCD, 1'b1, 1'b0,
           6, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'h0030);
        op("rt2", 2'b10, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1,
           6, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0030);

        // Forward then backward on its result
        op("fwd", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0,
           3, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000);
        op("bwd", 2'b01, 16'h0000, 16'hFFFF, 1'b0, 1'b1,
           4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h000C);

        // Fault injection: err_count 0 -> 1
        fault = 1'b1;
        op("fault", 2'b10, 16'h1234, 16'hABCD, 1'b1, 1'b0,
           6, 16'h1235, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'h0030);
        fault = 1'b0;

        // Illegal mode
        op("ill", 2'b11, 16'h5555, 16'hAAAA, 1'b1, 1'b1,
           1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Backpressure with a pending request behind the response
        send(2'b00, 16'h00FF, 16'h0F01, 1'b1, 1'b1);
        wait_rsp(lat, dmask);
        check("bp.lat", lat, 3);
        req_mode  = 2'b01;
        req_x     = 16'h1001;
        req_y     = 16'h00FF;
        req_c     = 1'b1;
        req_z     = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.valid", rsp_valid, 1);
            check("bp.x", rsp_x, 16'h1001);
            check("bp.y", rsp_y, 16'h00FF);
            check("bp.cz", {rsp_c, rsp_z}, 2'b11);
            check("bp.req_ready", req_ready, 0);
        end
        handshake();
        @(negedge clk);
        check("bp.ready_after", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(lat, dmask);
        check("bp2.lat", lat, 4);
        check("bp2.x", rsp_x, 16'h00FF);
        check("bp2.y", rsp_y, 16'h0F01);
        check("bp2.cz", {rsp_c, rsp_z}, 2'b11);
        handshake();

        // Saturation of err_count
        fault = 1'b1;
        while (exp_err < 255) begin
            op("sat", 2'b10, 16'h0F0F, 16'h00F0, 1'b0, 1'b1,
               6, 16'h0F0E, 16'h00F0, 1'b0, 1'b1, 1'b1, 16'h0030);
        end
        op("sat_hold", 2'b10, 16'h0F0F, 16'h00F0, 1'b0, 1'b1,
           6, 16'h0F0E, 16'h00F0, 1'b0, 1'b1, 1'b1, 16'h0030);
        check("sat.final", err_count, 255);
        fault = 1'b0;

        // Reset in the middle of a round trip
        send(2'b10, 16'h1234, 16'hABCD, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("mrst.dir_pre", dir, 1);
        rst_n = 1'b0;
        #1;
        check("mrst.dir", dir, 0);
        check("mrst.valid", rsp_valid, 0);
        check("mrst.err", err_count, 0);
        check("mrst.f_a", f_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mrst.no_rsp", rsp_valid, 0);
            check("mrst.dir_low", dir, 0);
        end
        check("mrst.ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
